booth_mult_sched: RTL

- Shared radix-4 Booth multiply engine with a round-robin front end. NREQ requesters compete for one iterative signed N×N multiplier.
- The block grants one request at a time and captures its operands.
- It sequences one Booth digit (3-bit multiplier window) per clock, accumulating shifted partial products.
- It returns the 2N-bit product tagged with the requester ID.
- It sits between the encoder/decoder datapath arrays and the client blocks that need products.

---
 rtl/booth_mult_sched.sv | 156 +++++++++++++++
 1 files changed

// File: rtl/booth_mult_sched.sv
// Round-robin front end sharing one iterative radix-4 Booth signed multiplier among NREQ requesters.
// Optional BOOTH_EARLY_TERM_EN: finish as soon as the remaining multiplier digits are all zero.
//
// state  | meaning
// IDLE   | waiting for a request; grants and captures operands combinationally-selected
// STEP   | one Booth digit per clock into the accumulator
// DONE   | product valid, done pulse
module booth_mult_sched #(
  parameter int N    = 8,
  parameter int NREQ = 4,
  parameter int IDW  = 2
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [NREQ-1:0]   req,
  input  logic [NREQ*N-1:0] md_in,
  input  logic [NREQ*N-1:0] mr_in,
  output logic [NREQ-1:0]   gnt,
  output logic              busy,
  output logic              done,
  output logic [IDW-1:0]    done_id,
  output logic [2*N-1:0]    product
);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_STEP = 2'd1;
  localparam logic [1:0] S_DONE = 2'd2;

  localparam int SW = $clog2(N/2) + 1;
  localparam logic [SW-1:0] LAST_STEP = SW'(N/2 - 1);

  logic [1:0]     r_state;
  logic [IDW-1:0] r_ptr;
  logic [IDW-1:0] r_id;
  logic [SW-1:0]  r_step;
  logic [2*N-1:0] r_acc;
  logic [2*N-1:0] r_md_sh;
  // multiplier with an implicit 0 below bit 0; low 3 bits are always the current Booth window
  logic [N:0]     r_mr_sh;
  logic [2*N-1:0] r_product;
  logic [IDW-1:0] r_done_id;

  logic           w_found;
  logic [IDW-1:0] w_sel;
  logic [IDW-1:0] w_idx;
  logic [IDW-1:0] w_ptr_next;
  logic [N-1:0]   w_md;
  logic [N-1:0]   w_mr;
  logic [NREQ-1:0] w_gnt;
  logic [2*N-1:0] w_pp;
  logic [2*N-1:0] w_acc_next;
  logic           w_last;

  always_comb begin
    w_found = 1'b0;
    w_sel   = '0;
    w_idx   = '0;
    for (int off = 0; off < NREQ; off++) begin
      w_idx = IDW'((int'(r_ptr) + off) % NREQ);
      if (!w_found && req[w_idx]) begin
        w_found = 1'b1;
        w_sel   = w_idx;
      end
    end
  end

  always_comb begin
    w_md = '0;
    w_mr = '0;
    for (int k = 0; k < NREQ; k++) begin
      if (w_sel == IDW'(k)) begin
        w_md = md_in[k*N +: N];
        w_mr = mr_in[k*N +: N];
      end
    end
  end

  assign w_ptr_next = (w_sel == IDW'(NREQ - 1)) ? '0 : w_sel + IDW'(1);

  always_comb begin
    w_gnt = '0;
    if (r_state == S_IDLE && !reset && w_found) begin
      w_gnt[w_sel] = 1'b1;
    end
  end

  always_comb begin
    w_pp = '0;
    case (r_mr_sh[2:0])
      3'b001, 3'b010: w_pp = r_md_sh;
      3'b011:         w_pp = r_md_sh << 1;
      3'b100:         w_pp = -(r_md_sh << 1);
      3'b101, 3'b110: w_pp = -r_md_sh;
      default:        w_pp = '0;
    endcase
  end

  assign w_acc_next = r_acc + w_pp;

`ifdef BOOTH_EARLY_TERM_EN
  // r_mr_sh[N:2] holds the unprocessed multiplier bits plus sign fill; uniform means only zero digits remain
  logic w_rest_zero;
  assign w_rest_zero = (r_mr_sh[N:2] == '0) || (&r_mr_sh[N:2]);
  assign w_last      = (r_step == LAST_STEP) || w_rest_zero;
`else
  assign w_last      = (r_step == LAST_STEP);
`endif

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state   <= S_IDLE;
      r_ptr     <= '0;
      r_id      <= '0;
      r_step    <= '0;
      r_acc     <= '0;
      r_md_sh   <= '0;
      r_mr_sh   <= '0;
      r_product <= '0;
      r_done_id <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (w_found) begin
            r_md_sh <= {{N{w_md[N-1]}}, w_md};
            r_mr_sh <= {w_mr, 1'b0};
            r_id    <= w_sel;
            r_acc   <= '0;
            r_step  <= '0;
            r_ptr   <= w_ptr_next;
            r_state <= S_STEP;
          end
        end
        S_STEP: begin
          r_acc   <= w_acc_next;
          r_md_sh <= r_md_sh << 2;
          r_mr_sh <= {{2{r_mr_sh[N]}}, r_mr_sh[N:2]};
          r_step  <= r_step + SW'(1);
          if (w_last) begin
            r_product <= w_acc_next;
            r_done_id <= r_id;
            r_state   <= S_DONE;
          end
        end
        S_DONE:  r_state <= S_IDLE;
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign gnt     = w_gnt;
  assign busy    = (r_state != S_IDLE);
  assign done    = (r_state == S_DONE);
  assign done_id = r_done_id;
  assign product = r_product;

endmodule
